// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one four-phase-handshake RAM port between two requesters.
// Per-port response registers (rdata/done/err) live in a small sub-module instanced per port.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 0
`endif
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 1
`endif
`ifndef RAM_ACK
`define RAM_ACK 0
`endif

module ram_arbiter_port #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cap,
    input  logic [W-1:0] rd_in,
    input  logic         fin,
    input  logic         err_in,
    output logic [W-1:0] rdata,
    output logic         done,
    output logic         err
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (cap) rdata <= rd_in;
            done <= fin;
            err  <= fin & err_in;
        end
    end
endmodule

module ram_arbiter #(
    parameter int WORD_WIDTH    = `WORD_WIDTH,
    parameter int RAM_READ_PIN  = `RAM_READ_PIN,
    parameter int RAM_WRITE_PIN = `RAM_WRITE_PIN,
    parameter int RAM_ACK       = `RAM_ACK,
    parameter int TIMEOUT       = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [WORD_WIDTH-1:0] p0_addr,
    input  logic [WORD_WIDTH-1:0] p0_wdata,
    output logic [WORD_WIDTH-1:0] p0_rdata,
    output logic                  p0_done,
    output logic                  p0_err,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [WORD_WIDTH-1:0] p1_addr,
    input  logic [WORD_WIDTH-1:0] p1_wdata,
    output logic [WORD_WIDTH-1:0] p1_rdata,
    output logic                  p1_done,
    output logic                  p1_err,
    input  logic [WORD_WIDTH-1:0] ram_stat,
    output logic [WORD_WIDTH-1:0] ram_ctrl,
    output logic [WORD_WIDTH-1:0] addr,
    output logic [WORD_WIDTH-1:0] data_out,
    input  logic [WORD_WIDTH-1:0] data_in
);
    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, DONE} state_t;
    state_t state, state_next;

    logic [1:0]                 req, we, done_a, err_a;
    logic [1:0][WORD_WIDTH-1:0] p_addr, p_wdata, rdata_a;
    logic [WORD_WIDTH-1:0]      pin;
    logic                       ack, sel, start, hit, expire, fin;
    logic                       grant, last_grant, we_q, err_flag;
    logic [15:0]                timer;
    logic                       unused_stat;

    assign req     = {p1_req, p0_req};
    assign we      = {p1_we, p0_we};
    assign p_addr  = {p1_addr, p0_addr};
    assign p_wdata = {p1_wdata, p0_wdata};
    assign ack     = ram_stat[RAM_ACK];
    assign unused_stat = ^ram_stat;

    // On a tie the port that did not win last time gets the RAM.
    assign sel = (req == 2'b11) ? ~last_grant : req[1];
    assign pin = WORD_WIDTH'(1) << (we[sel] ? RAM_WRITE_PIN : RAM_READ_PIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        hit        = 1'b0;
        expire     = 1'b0;
        fin        = 1'b0;
        case (state)
            IDLE: begin
                // A stale ACK from the previous cycle must clear before a new issue.
                start = (|req) && !ack;
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                hit    = ack;
                expire = !ack && (timer == TLAST);
                if (hit || expire) state_next = RELEASE;
            end
            RELEASE: begin
                fin = !ack;
                if (fin) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            err_flag   <= 1'b0;
            timer      <= '0;
            ram_ctrl   <= '0;
            addr       <= '0;
            data_out   <= '0;
        end else if (start) begin
            grant      <= sel;
            last_grant <= sel;
            we_q       <= we[sel];
            addr       <= p_addr[sel];
            if (we[sel]) data_out <= p_wdata[sel];
            ram_ctrl   <= pin;
            timer      <= '0;
        end else if (hit) begin
            ram_ctrl <= '0;
            err_flag <= 1'b0;
        end else if (expire) begin
            ram_ctrl <= '0;
            err_flag <= 1'b1;
        end else if (state == ISSUE) begin
            timer <= timer + 16'd1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_port
        ram_arbiter_port #(.W(WORD_WIDTH)) u_port (
            .clk    (clk),
            .rst_n  (rst_n),
            .cap    (hit && !we_q && (grant == 1'(i))),
            .rd_in  (data_in),
            .fin    (fin && (grant == 1'(i))),
            .err_in (err_flag),
            .rdata  (rdata_a[i]),
            .done   (done_a[i]),
            .err    (err_a[i])
        );
    end

    assign p0_rdata = rdata_a[0];
    assign p1_rdata = rdata_a[1];
    assign p0_done  = done_a[0];
    assign p1_done  = done_a[1];
    assign p0_err   = err_a[0];
    assign p1_err   = err_a[1];
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: main instance with a delay-programmable RAM model,
// second instance with TIMEOUT=4 for the no-ACK case.
module tb_ram_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         p0_req, p0_we, p0_done, p0_err;
    logic [W-1:0] p0_addr, p0_wdata, p0_rdata;
    logic         p1_req, p1_we, p1_done, p1_err;
    logic [W-1:0] p1_addr, p1_wdata, p1_rdata;
    logic [W-1:0] ram_stat, ram_ctrl, addr, data_out, data_in;

    logic         ram_force, ack;
    logic [15:0]  ram_delay, pin_cnt;

    logic         t_req, t_ack_en, t_done, t_err;
    logic [W-1:0] t_stat, t_ctrl, t_addr, t_dout, t_rdata;
    logic [W-1:0] unused_rdata;
    logic         unused_done, unused_err;

    int checks = 0;
    int errors = 0;
    int seq[4];
    int n, both, pins, dn, er, lat, first;
    logic got;

    // RAM model: ACK rises once the pin has been high for ram_delay cycles, falls with the pin.
    always @(posedge clk or negedge rst_n)
        if (!rst_n)              pin_cnt <= '0;
        else if (ram_ctrl != '0) pin_cnt <= pin_cnt + 16'd1;
        else                     pin_cnt <= '0;
    assign ack      = ram_force | ((ram_ctrl != '0) && (pin_cnt >= ram_delay));
    assign ram_stat = {{(W-1){1'b0}}, ack};
    assign t_stat   = {{(W-1){1'b0}}, t_ack_en && (t_ctrl != '0)};

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err),
        .ram_stat(ram_stat), .ram_ctrl(ram_ctrl), .addr(addr),
        .data_out(data_out), .data_in(data_in)
    );

    ram_arbiter #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .p0_req(t_req), .p0_we(1'b0), .p0_addr(32'h40), .p0_wdata(32'h0),
        .p0_rdata(t_rdata), .p0_done(t_done), .p0_err(t_err),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0),
        .p1_rdata(unused_rdata), .p1_done(unused_done), .p1_err(unused_err),
        .ram_stat(t_stat), .ram_ctrl(t_ctrl), .addr(t_addr),
        .data_out(t_dout), .data_in(32'h5A5A5A5A)
    );

    task automatic chk(input string tag, input logic [W-1:0] got_v, input logic [W-1:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        ram_force = 0; ram_delay = 0; data_in = 32'hDEADBEEF;
        t_req = 0; t_ack_en = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        tick();
        chk("rst_ctrl", ram_ctrl, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_rdata", p0_rdata, 0);
        chk("rst_done", 32'({p1_done, p0_done}), 0);

        // single read on port 0, zero-wait RAM
        p0_req = 1; p0_we = 0; p0_addr = 32'h10;
        tick(); chk("rd_pin", ram_ctrl, 32'h1); chk("rd_addr", addr, 32'h10);
        tick(); chk("rd_release", ram_ctrl, 0); chk("rd_early", 32'(p0_done), 0);
        tick(); chk("rd_done", 32'(p0_done), 1); chk("rd_data", p0_rdata, 32'hDEADBEEF);
        chk("rd_err", 32'(p0_err), 0); p0_req = 0;
        tick(); chk("rd_pulse", 32'(p0_done), 0);

        // write on port 1, ACK five cycles late
        p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h1234;
        ram_delay = 5; data_in = 32'h0BADF00D;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("wr_pin", ram_ctrl, 32'h2);
            chk("wr_addr", addr, 32'h20);
            chk("wr_dout", data_out, 32'h1234);
        end
        tick(); chk("wr_release", ram_ctrl, 0);
        tick(); chk("wr_done", 32'(p1_done), 1); chk("wr_err", 32'(p1_err), 0);
        chk("wr_rdata", p1_rdata, 0); chk("wr_p0", 32'(p0_done), 0); p1_req = 0;
        tick(); chk("wr_pulse", 32'(p1_done), 0);

        // both ports requesting after reset alternate 0,1,0,1
        rst_n = 0; tick(); rst_n = 1;
        ram_delay = 0; data_in = 32'hDEADBEEF; p1_we = 0;
        for (int k = 0; k < 4; k++) seq[k] = -1;
        n = 0; both = 0;
        p0_req = 1; p1_req = 1;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick();
            if (p0_done && p1_done) both++;
            if (p0_done || p1_done) begin
                seq[n] = p1_done ? 1 : 0;
                n++;
                if (n == 4) begin p0_req = 0; p1_req = 0; end
            end
        end
        p0_req = 0; p1_req = 0;
        chk("alt_count", n, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("alt_grant%0d", k), seq[k], k % 2);
        chk("alt_both", both, 0);
        tick();

        // timeout instance: RAM never acks
        pins = 0; dn = 0; er = 0;
        t_req = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (t_ctrl != '0) pins++;
            if (t_done) begin
                dn++;
                if (t_err) er++;
                t_req = 0;
            end
        end
        chk("to_pins", pins, 4);
        chk("to_done", dn, 1);
        chk("to_err", er, 1);
        t_ack_en = 1; t_req = 1; got = 0; lat = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick(); lat++;
            if (t_done) got = 1;
        end
        chk("to_next_lat", lat, 3);
        chk("to_next_err", 32'(t_err), 0);
        chk("to_next_rdata", t_rdata, 32'h5A5A5A5A);
        t_req = 0;

        // stale ACK blocks issue until seen low
        ram_force = 1; p1_req = 1; p1_we = 0; p1_addr = 32'h30; data_in = 32'h600DCAFE;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("stale_block", ram_ctrl, 0);
        end
        ram_force = 0;
        tick(); chk("stale_issue", ram_ctrl, 32'h1); chk("stale_addr", addr, 32'h30);
        tick(); tick();
        chk("stale_done", 32'(p1_done), 1); chk("stale_rdata", p1_rdata, 32'h600DCAFE);
        p1_req = 0;
        tick();

        // reset during ISSUE drops the transfer
        ram_delay = 10; p0_req = 1; p0_we = 0; p0_addr = 32'h44;
        tick(); tick(); chk("mid_pin", ram_ctrl, 32'h1);
        rst_n = 0; #1;
        chk("mid_rst_ctrl", ram_ctrl, 0);
        chk("mid_rst_rdata", p0_rdata, 0);
        chk("mid_rst_done", 32'({p1_done, p0_done}), 0);
        p0_req = 0;
        tick(); tick(); rst_n = 1;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (p0_done || p1_done || ram_ctrl != '0) dn++;
        end
        chk("mid_quiet", dn, 0);
        ram_delay = 0; data_in = 32'hCAFEF00D;
        p0_req = 1; p1_req = 1; p1_we = 0; got = 0; first = -1;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (p0_done || p1_done) begin
                got = 1;
                first = p1_done ? 1 : 0;
                p0_req = 0; p1_req = 0;
            end
        end
        p0_req = 0; p1_req = 0;
        chk("post_rst_first", first, 0);
        chk("post_rst_rdata", p0_rdata, 32'hCAFEF00D);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single motherboard RAM port (`ram_ctrl`/`ram_stat`/`addr`/`data_out`/`data_in`) between two requesters: port 0 (CPU bus sequencer) and port 1 (loader/DMA). It grants one request at a time using round-robin priority. It drives the RAM four-phase ACK handshake: assert pin, wait ACK high, drop pin, wait ACK low. It returns a one-cycle `done` pulse, plus read data or a timeout error, to the granted requester.

## Interface
Parameters:
- `WORD_WIDTH`, default `` `WORD_WIDTH `` (32): data, address and control word width.
- `RAM_READ_PIN`, default `` `RAM_READ_PIN `` (0): bit of `ram_ctrl` that requests a read.
- `RAM_WRITE_PIN`, default `` `RAM_WRITE_PIN `` (1): bit of `ram_ctrl` that requests a write.
- `RAM_ACK`, default `` `RAM_ACK `` (0): bit of `ram_stat` that carries the RAM acknowledge.
- `TIMEOUT`, default 255: maximum number of ISSUE cycles to wait for ACK high; range 1..65535.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` — in — 1 — clock; all state changes on its rising edge.
  - `rst_n` — in — 1 — asynchronous, active-low reset.
- Requester ports, for x = 0, 1:
  - `px_req` — in — 1 — request; held with `px_we`, `px_addr` and `px_wdata` stable until `px_done`.
  - `px_we` — in — 1 — 1 = write, 0 = read.
  - `px_addr` — in — WORD_WIDTH — translated address.
  - `px_wdata` — in — WORD_WIDTH — write data.
  - `px_rdata` — out — WORD_WIDTH — read data; valid from the `px_done` cycle and held until the next successful read on this port.
  - `px_done` — out — 1 — one-cycle completion pulse.
  - `px_err` — out — 1 — asserted together with `px_done` when the transfer timed out.
- RAM port:
  - `ram_stat` — in — WORD_WIDTH — RAM status; only bit `RAM_ACK` is used.
  - `ram_ctrl` — out — WORD_WIDTH — one-hot read or write pin; all other bits are always 0.
  - `addr` — out — WORD_WIDTH — RAM address.
  - `data_out` — out — WORD_WIDTH — RAM write data.
  - `data_in` — in — WORD_WIDTH — RAM read data.

## Operation
- All outputs are registered. Reset value of every output is 0. After reset the state is IDLE and `last_grant` = 1, so port 0 wins the first tie.
- States and transitions:
  - **IDLE**: grant only if at least one `req` is high AND `ram_stat[RAM_ACK]` = 0. A stale ACK blocks issue.
    - Only one `req` high: grant that port.
    - Both `req` high: grant the port ≠ `last_grant`.
    - On grant: latch the port into `grant` and set `last_grant` to it. Load `addr` = `px_addr`. Load `data_out` = `px_wdata` on a write; `data_out` is unchanged on a read. Set the selected pin in `ram_ctrl`. Clear the timer. Go to ISSUE.
  - **ISSUE**: `ram_ctrl` pin held.
    - ACK = 1: `ram_ctrl` <= 0. On a read, capture `data_in` into `pgrant_rdata`. Go to RELEASE with `err_flag` = 0.
    - Timer = TIMEOUT-1 and ACK still 0: `ram_ctrl` <= 0, `err_flag` = 1, go to RELEASE.
    - Otherwise: timer++.
  - **RELEASE**: wait for ACK = 0, then pulse `pgrant_done` (and `pgrant_err` = `err_flag`) and go to DONE.
  - **DONE**: one cycle with `done` high; then go to IDLE. `done` and `err` clear.
- `addr` and `data_out` hold their values after the transfer; they are don't-care to the RAM while `ram_ctrl` = 0.
- Requests are not inspected outside IDLE. Requester changes to `req`, `we`, `addr` or `wdata` mid-transfer are ignored; the latched grant is served.
- A requester must drop `req` in the cycle after `done`. A `req` still high in IDLE after DONE is treated as a new request.
- Timer width is 16 bits with no wrap, because TIMEOUT ≤ 65535.

## Timing
- Request seen in IDLE at cycle 0 → `ram_ctrl` pin high in cycle 1.
- ACK high sampled at the end of cycle k (k ≥ 1) → `ram_ctrl` = 0 in cycle k+1.
- ACK low sampled at the end of cycle m (m ≥ k+1) → `done` high in cycle m+1 → IDLE in cycle m+2.
- Minimum transfer with a zero-wait RAM: request in cycle 0, `done` in cycle 3. Next grant no earlier than cycle 4.
- Timeout: pin high for exactly TIMEOUT cycles, then dropped; `done` and `err` follow once ACK = 0.
- Reset mid-operation: `ram_ctrl`, `done` and `err` go to 0 asynchronously. The in-flight transfer is dropped with no `done`. `rdata` is cleared.

## Test plan
- **Single read, port 0**: `p0_addr` = 0x10; RAM acks 1 cycle after the pin and returns `data_in` = 0xDEADBEEF → `ram_ctrl` = 0x1; `p0_rdata` = 0xDEADBEEF with `p0_done` pulse 3 cycles after the request; `p0_err` = 0.
- **Write, port 1**: `p1_addr` = 0x20, `p1_wdata` = 0x1234, RAM ACK delayed 5 cycles → `ram_ctrl` = 0x2, `addr` = 0x20 and `data_out` = 0x1234 throughout ISSUE; `p1_done` once; `p1_rdata` unchanged.
- **Simultaneous requests after reset**: both ports request continuously → grants alternate 0, 1, 0, 1 over 4 transfers; never two `done` pulses in the same cycle.
- **Timeout**: TIMEOUT = 4, RAM never acks → pin high exactly 4 cycles; `p0_done` = `p0_err` = 1 for one cycle; the next request is served normally.
- **Stale ACK**: ACK held high while `p1_req` rises → no pin asserted until ACK = 0; issue happens in the cycle after ACK is seen low.
- **Reset mid-ISSUE**: `rst_n` low during a read → `ram_ctrl` = 0 immediately; no `done`; after release a new request completes correctly with port 0 priority.
